uart_tx_arbiter: RTL

// Shares the single UART transmitter among N_REQ byte-stream requesters (Hough result

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter among N_REQ requesters.
// Optional forced release of a silent packet owner is enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int N_REQ    = 3,
   parameter int ACK_WAIT = 4,
   parameter int TIMEOUT  = 65535
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   input  logic               tx_busy,
   output logic               grant_valid,
   output logic [2:0]         grant_id,
   output logic               timeout_err
);
   localparam int AW = $clog2(ACK_WAIT + 1);
   typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;
   state_t state, state_nx;
   logic [2:0] ptr, ptr_nx, gid_nx, win;
   logic [N_REQ-1:0] g_oh;
   logic [7:0] data_nx, sel_data;
   logic [AW-1:0] ack_cnt, ack_nx;
   logic gv_nx, start_nx, last_q, last_nx, g_valid, sel_last, accept, to_hit;

   assign g_oh      = N_REQ'(1) << grant_id;
   assign g_valid   = |(req_valid & g_oh);
   assign sel_last  = |(req_last & g_oh);
   assign sel_data  = 8'(req_data >> (8 * grant_id));
   assign req_ready = (state == LOAD && !tx_busy) ? g_oh : '0;
   assign accept    = |(req_valid & req_ready);

   // Scan from the farthest candidate back to ptr+1 so the nearest valid requester wins.
   always_comb begin
      win = '0;
      for (int k = N_REQ; k >= 1; k--)
         if (((req_valid >> ((int'(ptr) + k) % N_REQ)) & N_REQ'(1)) != '0)
            win = 3'((int'(ptr) + k) % N_REQ);
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      gid_nx   = grant_id;
      gv_nx    = grant_valid;
      data_nx  = tx_data;
      start_nx = 1'b0;
      last_nx  = last_q;
      ack_nx   = '0;
      case (state)
         IDLE:
            if (|req_valid) begin
               state_nx = LOAD;
               gv_nx    = 1'b1;
               gid_nx   = win;
            end
         LOAD:
            if (accept) begin
               state_nx = WAIT_ACK;
               data_nx  = sel_data;
               last_nx  = sel_last;
               start_nx = 1'b1;
            end else if (to_hit) begin
               state_nx = IDLE;
               gv_nx    = 1'b0;
               ptr_nx   = grant_id;
            end
         WAIT_ACK: begin
            ack_nx = ack_cnt + 1'b1;
            if (tx_busy || ack_cnt == AW'(ACK_WAIT - 1)) state_nx = WAIT_DONE;
         end
         WAIT_DONE:
            if (!tx_busy) begin
               state_nx = last_q ? IDLE : LOAD;
               gv_nx    = !last_q;
               ptr_nx   = last_q ? grant_id : ptr;
            end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (reset) begin
         state       <= IDLE;
         ptr         <= 3'(N_REQ - 1);
         grant_id    <= '0;
         grant_valid <= 1'b0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         last_q      <= 1'b0;
         ack_cnt     <= '0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         grant_id    <= gid_nx;
         grant_valid <= gv_nx;
         tx_data     <= data_nx;
         tx_start    <= start_nx;
         last_q      <= last_nx;
         ack_cnt     <= ack_nx;
      end

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt;
   logic idle_own;
   assign idle_own = state == LOAD && !g_valid;
   assign to_hit   = idle_own && to_cnt == TW'(TIMEOUT - 1);
   always_ff @(posedge clk)
      if (reset) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         to_cnt      <= (idle_own && !to_hit) ? to_cnt + 1'b1 : '0;
         timeout_err <= to_hit;
      end
`else
   localparam int unused_timeout = TIMEOUT;
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif
endmodule
